// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin burst drain of NCH show-ahead FIFOs into a
// single registered valid/ready output stage tagged with the source channel.
module fifo_drain_arbiter #(
  parameter int NCH    = 4,
  parameter int DWID   = 8,
  parameter int BURSTW = 3,
  parameter int CHW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      fifo_empty,
  input  logic [NCH*DWID-1:0] fifo_rdata,
  output logic [NCH-1:0]      fifo_rd_en,
  input  logic [BURSTW-1:0]   cfg_burst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWID-1:0]     out_data,
  output logic [CHW-1:0]      out_ch,
  output logic [NCH-1:0]      grant,
  output logic                busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [BURSTW:0] CNT_ONE  = {{BURSTW{1'b0}}, 1'b1};
  localparam logic [BURSTW:0] CNT_FULL = {1'b1, {BURSTW{1'b0}}};
  localparam logic [NCH-1:0]  ONEHOT0  = {{(NCH-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [NCH-1:0]  r_grant;
  logic [CHW-1:0]  r_gidx;
  logic [CHW-1:0]  r_last;
  logic [BURSTW:0] r_cnt;
  logic            r_busy;
  logic            r_out_valid;
  logic [DWID-1:0] r_out_data;
  logic [CHW-1:0]  r_out_ch;

  logic [DWID-1:0] w_rdata [NCH];
  logic            w_any;
  logic [CHW-1:0]  w_sel;
  logic [NCH-1:0]  w_req_rot;
  logic [NCH-1:0]  w_onehot;
  logic            w_g_empty;
  logic            w_rd;
  logic [BURSTW:0] w_burst_load;
  logic            w_exit;

  // Unpack the flat read-data bus into one word per channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_rdata[i] = fifo_rdata[i*DWID +: DWID];
    end
  end

  // Round-robin pick: first non-empty channel starting at last+1, wrapping.
  // Walking the distance downward lets the nearest candidate win last.
  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_any     = |(~fifo_empty);
    w_sel     = '0;
    w_req_rot = '0;
    for (int k = NCH; k >= 1; k--) begin
      v_idx     = (int'(r_last) + k) % NCH;
      w_req_rot = (~fifo_empty) >> v_idx;
      if (w_req_rot[0]) begin
        w_sel = CHW'(v_idx);
      end else begin
        w_sel = w_sel;
      end
    end
    w_onehot = ONEHOT0 << w_sel;
  end

  // Read qualification for the owning channel and burst length decode.
  always_comb begin
    w_g_empty    = fifo_empty[r_gidx];
    w_rd         = (r_state == ST_GRANT) && !w_g_empty && (!r_out_valid || out_ready);
    fifo_rd_en   = r_grant & {NCH{w_rd}};
    w_exit       = (w_rd && (r_cnt == CNT_ONE)) || w_g_empty;
    if (cfg_burst == '0) begin
      w_burst_load = CNT_FULL;
    end else begin
      w_burst_load = {1'b0, cfg_burst};
    end
  end

  // Arbitration FSM: grant owner, burst counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= CHW'(NCH - 1);
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_grant <= w_onehot;
            r_gidx  <= w_sel;
            r_last  <= w_sel;
            r_cnt   <= w_burst_load;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_rd) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_cnt <= r_cnt;
          end
          if (w_exit) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_GRANT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on every pop, drop valid once accepted with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_rd) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_rdata[r_gidx];
      r_out_ch    <= r_gidx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter with behavioural show-ahead FIFOs.
module tb_fifo_drain_arbiter;

  localparam int NCH = 4;
  localparam int DWID = 8;
  localparam int BURSTW = 3;
  localparam int CHW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      fifo_empty;
  logic [NCH*DWID-1:0] fifo_rdata;
  logic [NCH-1:0]      fifo_rd_en;
  logic [BURSTW-1:0]   cfg_burst;
  logic                out_valid;
  logic                out_ready;
  logic [DWID-1:0]     out_data;
  logic [CHW-1:0]      out_ch;
  logic [NCH-1:0]      grant;
  logic                busy;

  fifo_drain_arbiter #(.NCH(NCH), .DWID(DWID), .BURSTW(BURSTW), .CHW(CHW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .cfg_burst(cfg_burst), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO models: word value = ch*16 + absolute index within that channel.
  logic [7:0] mem [NCH][64];
  int head [NCH];
  int tail [NCH];
  int log_q [$];
  int viol = 0;
  int n_cmp = 0;
  int n_err = 0;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      fifo_empty[i] = (head[i] == tail[i]);
      fifo_rdata[i*DWID +: DWID] = mem[i][head[i]];
    end
  end

  always @(posedge clk) begin
    if (!$onehot0(fifo_rd_en)) viol = viol + 1;
    for (int i = 0; i < NCH; i++) begin
      if (fifo_rd_en[i]) begin
        if (fifo_empty[i]) viol = viol + 1;
        head[i] <= head[i] + 1;
      end
    end
    if (!rst && out_valid && out_ready) log_q.push_back(int'(out_ch) * 256 + int'(out_data));
  end

  task automatic push(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      mem[ch][tail[ch]] = 8'(ch * 16 + tail[ch]);
      tail[ch] = tail[ch] + 1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int pos, input int ch, input int idx);
    int v;
    v = (pos < log_q.size()) ? log_q[pos] : -1;
    chk($sformatf("%s[%0d]", tag, pos), v, ch * 256 + ch * 16 + idx);
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (log_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, log_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    out_ready = 1'b1;
    cfg_burst = 3'd2;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);

    // Test 1: four channels, 2 words each, burst 2
    for (int ch = 0; ch < NCH; ch++) push(ch, 2);
    log_q.delete();
    rst = 1'b0;
    wait_words("t1_count", 8, 80);
    for (int p = 0; p < 8; p++) chk_log("t1_word", p, p / 2, p % 2);

    // Test 2: only ch2, 5 words, burst 0 (=8), exit on empty
    cfg_burst = 3'd0;
    log_q.delete();
    push(2, 5);
    wait_words("t2_count", 5, 40);
    for (int p = 0; p < 5; p++) chk_log("t2_word", p, 2, 2 + p);
    repeat (2) @(negedge clk);
    chk("t2_busy", int'(busy), 0);
    chk("t2_grant", int'(grant), 0);
    chk("t2_pops_ch0", head[0], 2);
    chk("t2_pops_ch1", head[1], 2);
    chk("t2_pops_ch2", head[2], 7);
    chk("t2_pops_ch3", head[3], 2);

    // Test 6: all empty for 20 cycles
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t6_rd_en", int'(fifo_rd_en), 0);
      chk("t6_out_valid", int'(out_valid), 0);
      chk("t6_busy", int'(busy), 0);
    end

    // Test 4: stall 4 cycles after the first word of a ch0 burst of 3
    cfg_burst = 3'd3;
    log_q.delete();
    push(0, 4);
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("t4_first_valid", int'(out_valid), 1);
    out_ready = 1'b0;
    chk("t4_first_data", int'(out_data), 8'h02);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_stall_valid", int'(out_valid), 1);
      chk("t4_stall_data", int'(out_data), 8'h02);
      chk("t4_stall_ch", int'(out_ch), 0);
      chk("t4_stall_rd_en", int'(fifo_rd_en), 0);
      chk("t4_stall_grant", int'(grant), 1);
    end
    out_ready = 1'b1;
    wait_words("t4_count3", 3, 20);
    chk("t4_burst_end_bubble", int'(out_valid), 0);
    for (int p = 0; p < 3; p++) chk_log("t4_word", p, 0, 2 + p);
    wait_words("t4_count4", 4, 20);
    chk_log("t4_word", 3, 0, 5);

    // Test 3: ch1 10 words, ch3 1 word, burst 3, from reset
    @(negedge clk);
    rst = 1'b1;
    cfg_burst = 3'd3;
    push(1, 10);
    push(3, 1);
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    wait_words("t3_count", 11, 100);
    chk_log("t3_word", 0, 1, 2);
    chk_log("t3_word", 1, 1, 3);
    chk_log("t3_word", 2, 1, 4);
    chk_log("t3_word", 3, 3, 2);
    for (int p = 4; p < 11; p++) chk_log("t3_word", p, 1, p + 1);

    // Test 5: reset mid-burst with cnt=2, then restart from ch0
    cfg_burst = 3'd4;
    log_q.delete();
    push(0, 6);
    push(1, 2);
    wait_words("t5_pre_count", 1, 20);
    chk_log("t5_pre_word", 0, 0, 6);
    chk("t5_inflight_data", int'(out_data), 8'h07);
    rst = 1'b1;
    #1;
    chk("t5_async_out_valid", int'(out_valid), 0);
    chk("t5_async_grant", int'(grant), 0);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_out_data", int'(out_data), 0);
    chk("t5_async_rd_en", int'(fifo_rd_en), 0);
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    wait_words("t5_count", 6, 60);
    for (int p = 0; p < 4; p++) chk_log("t5_word", p, 0, 8 + p);
    chk_log("t5_word", 4, 1, 12);
    chk_log("t5_word", 5, 1, 13);
    chk("t5_pops_ch0", head[0], 12);
    chk("t5_pops_ch1", head[1], 14);

    chk("no_bad_rd_en", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
